// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, request priority and the
// per-stage control bundle.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_BR_STALL  = 3'd1,
    ST_MEM_WAIT  = 3'd2,
    ST_IRQ_DRAIN = 3'd3,
    ST_IRQ_REDIR = 3'd4
  } pipe_state_e;

  // Requests seen in RUN once mem_busy is ruled out, highest priority first in pick_req.
  typedef enum logic [2:0] {
    REQ_NONE     = 3'd0,
    REQ_REDIRECT = 3'd1,
    REQ_LOAD_USE = 3'd2,
    REQ_BR_DEP   = 3'd3,
    REQ_IRQ      = 3'd4
  } pipe_req_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam stage_ctrl_t CTRL_RESET  = 7'b00000_11;
  localparam stage_ctrl_t CTRL_HOLD   = 7'b00000_00;
  localparam stage_ctrl_t CTRL_BUBBLE = 7'b00111_01;
  localparam stage_ctrl_t CTRL_KILL   = 7'b11111_10;
  localparam stage_ctrl_t CTRL_DRAIN  = 7'b01111_11;
  localparam stage_ctrl_t CTRL_REDIR  = 7'b11111_10;

  // br_dep outranks load_use: its stall is a superset of the load-use bubble.
  function automatic pipe_req_e pick_req(input logic irq_req, input logic load_use,
                                         input logic br_dep, input logic redirect);
    pipe_req_e r;
    r = REQ_NONE;
    if (irq_req)       r = REQ_IRQ;
    else if (br_dep)   r = REQ_BR_DEP;
    else if (load_use) r = REQ_LOAD_USE;
    else if (redirect) r = REQ_REDIRECT;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// Loadable saturating down-counter with hold; 'last' flags the final counted cycle.
module pipe_stall_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count <= W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional event counters are built
// when PIPE_STALL_STATS_EN is defined.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_STALL_CYC = 1,
  parameter int DRAIN_CYC    = 3,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             br_dep,
  input  logic             redirect,
  input  logic             mem_busy,
  input  logic             irq,
  input  logic             irq_en,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_sel_irq,
  output logic             epc_we,
  output logic             irq_ack,
  output pipe_state_e      state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [15:0]      irq_cnt
`endif
);

  localparam logic [CNT_W-1:0] BR_LOAD    = CNT_W'(BR_STALL_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  pipe_state_e      state, saved, eff_state, state_nx, saved_nx;
  pipe_req_e        req;
  stage_ctrl_t      ctrl, ctrl_out;
  logic             irq_pulse;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_load_val, cnt_val;

  // MEM_WAIT behaves as the interrupted state once mem_busy drops, so resumption is same-cycle.
  assign eff_state = (state == ST_MEM_WAIT) ? saved : state;
  assign req       = pick_req(irq & irq_en, load_use, br_dep, redirect);

  always_comb begin
    ctrl         = CTRL_RUN;
    irq_pulse    = 1'b0;
    state_nx     = state;
    saved_nx     = saved;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (mem_busy && (eff_state != ST_IRQ_REDIR)) begin
      ctrl     = CTRL_HOLD;
      state_nx = ST_MEM_WAIT;
      saved_nx = eff_state;
    end else begin
      case (eff_state)
        ST_RUN: begin
          state_nx = ST_RUN;
          case (req)
            REQ_IRQ: begin
              ctrl         = CTRL_DRAIN;
              cnt_load     = 1'b1;
              cnt_load_val = DRAIN_LOAD;
              state_nx     = (DRAIN_CYC > 1) ? ST_IRQ_DRAIN : ST_IRQ_REDIR;
            end
            REQ_BR_DEP: begin
              ctrl         = CTRL_BUBBLE;
              cnt_load     = 1'b1;
              cnt_load_val = BR_LOAD;
              state_nx     = (BR_STALL_CYC > 1) ? ST_BR_STALL : ST_RUN;
            end
            REQ_LOAD_USE: ctrl = CTRL_BUBBLE;
            REQ_REDIRECT: ctrl = CTRL_KILL;
            default:      ctrl = CTRL_RUN;
          endcase
        end
        ST_BR_STALL: begin
          ctrl     = CTRL_BUBBLE;
          cnt_dec  = 1'b1;
          state_nx = cnt_last ? ST_RUN : ST_BR_STALL;
        end
        ST_IRQ_DRAIN: begin
          ctrl     = CTRL_DRAIN;
          cnt_dec  = 1'b1;
          state_nx = cnt_last ? ST_IRQ_REDIR : ST_IRQ_DRAIN;
        end
        ST_IRQ_REDIR: begin
          ctrl      = CTRL_REDIR;
          irq_pulse = 1'b1;
          state_nx  = ST_RUN;
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      saved <= ST_RUN;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
    end
  end

  pipe_stall_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .last     (cnt_last)
  );

  assign ctrl_out   = reset ? CTRL_RESET : ctrl;
  assign pc_we      = ctrl_out.pc_we;
  assign ifid_we    = ctrl_out.ifid_we;
  assign idex_we    = ctrl_out.idex_we;
  assign exmem_we   = ctrl_out.exmem_we;
  assign memwb_we   = ctrl_out.memwb_we;
  assign ifid_flush = ctrl_out.ifid_flush;
  assign idex_flush = ctrl_out.idex_flush;
  assign pc_sel_irq = irq_pulse & ~reset;
  assign epc_we     = irq_pulse & ~reset;
  assign irq_ack    = irq_pulse & ~reset;
  assign state_dbg  = state;
  assign cnt_dbg    = cnt_val;

`ifdef PIPE_STALL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      irq_cnt   <= '0;
    end else begin
      if (!ctrl.pc_we)                      stall_cnt <= stall_cnt + 32'd1;
      if (ctrl.ifid_flush || ctrl.idex_flush) flush_cnt <= flush_cnt + 32'd1;
      if (irq_pulse)                        irq_cnt   <= irq_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with BR_STALL_CYC=2, DRAIN_CYC=3.
module tb_pipe_stall_ctrl;

  // Output vector: {pc,ifid,idex,exmem,memwb we, ifid_flush, idex_flush, pc_sel_irq, epc_we, irq_ack}
  localparam logic [9:0] RUN_V   = 10'b11111_00_000;
  localparam logic [9:0] RST_V   = 10'b00000_11_000;
  localparam logic [9:0] BUB_V   = 10'b00111_01_000;
  localparam logic [9:0] KILL_V  = 10'b11111_10_000;
  localparam logic [9:0] DRAIN_V = 10'b01111_11_000;
  localparam logic [9:0] HOLD_V  = 10'b00000_00_000;
  localparam logic [9:0] REDIR_V = 10'b11111_10_111;

  // Input vector: {load_use, br_dep, redirect, mem_busy, irq, irq_en}
  localparam logic [5:0] I_NONE    = 6'b000000;
  localparam logic [5:0] I_LU      = 6'b100000;
  localparam logic [5:0] I_BR      = 6'b010000;
  localparam logic [5:0] I_RD      = 6'b001000;
  localparam logic [5:0] I_MB      = 6'b000100;
  localparam logic [5:0] I_IRQ     = 6'b000011;
  localparam logic [5:0] I_IRQ_OFF = 6'b000010;

  logic clk, reset;
  logic load_use, br_dep, redirect, mem_busy, irq, irq_en;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush;
  logic pc_sel_irq, epc_we, irq_ack;
  pipe_pkg::pipe_state_e state_dbg;
  logic [2:0] cnt_dbg;
`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [15:0] irq_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];

  pipe_stall_ctrl #(.BR_STALL_CYC(2), .DRAIN_CYC(3), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_use   (load_use),
    .br_dep     (br_dep),
    .redirect   (redirect),
    .mem_busy   (mem_busy),
    .irq        (irq),
    .irq_en     (irq_en),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .idex_we    (idex_we),
    .exmem_we   (exmem_we),
    .memwb_we   (memwb_we),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .pc_sel_irq (pc_sel_irq),
    .epc_we     (epc_we),
    .irq_ack    (irq_ack),
    .state_dbg  (state_dbg),
    .cnt_dbg    (cnt_dbg)
`ifdef PIPE_STALL_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .irq_cnt    (irq_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush,
            pc_sel_irq, epc_we, irq_ack};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [5:0] in_v);
    {load_use, br_dep, redirect, mem_busy, irq, irq_en} = in_v;
  endtask

  // One pipeline cycle: inputs applied 1 time unit after the edge, outputs scored mid-cycle.
  task automatic cycle(input string tag, input logic [5:0] in_v, input logic [9:0] exp);
    logic [9:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    drive(in_v);
    #3;
    e = exp_q.pop_front();
    check(tag, {6'd0, outs()}, {6'd0, e});
  endtask

  initial begin
    reset = 1'b1;
    drive(I_NONE);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {6'd0, outs()}, {6'd0, RST_V});
    check("reset_state", {13'd0, state_dbg}, 16'd0);
    check("reset_cnt", {13'd0, cnt_dbg}, 16'd0);
    reset = 1'b0;
    #3;
    check("release", {6'd0, outs()}, {6'd0, RUN_V});

    cycle("idle0", I_NONE, RUN_V);
    cycle("idle1", I_NONE, RUN_V);

    cycle("lu", I_LU, BUB_V);
    cycle("lu_after", I_NONE, RUN_V);

    cycle("br_c1", I_BR, BUB_V);
    cycle("br_c2", I_NONE, BUB_V);
    check("br_state", {13'd0, state_dbg}, 16'd1);
    cycle("br_done", I_NONE, RUN_V);
    check("br_run", {13'd0, state_dbg}, 16'd0);

    cycle("lubr_c1", I_LU | I_BR, BUB_V);
    cycle("lubr_c2", I_NONE, BUB_V);
    cycle("lubr_done", I_NONE, RUN_V);

    cycle("irq_dis0", I_IRQ_OFF, RUN_V);
    cycle("irq_dis1", I_IRQ_OFF, RUN_V);

    cycle("irq_d1", I_IRQ, DRAIN_V);
    cycle("irq_d2", I_IRQ, DRAIN_V);
    cycle("irq_d3", I_IRQ, DRAIN_V);
    cycle("irq_redir", I_IRQ, REDIR_V);
    cycle("irq_after", I_NONE, RUN_V);

    cycle("irqdrop_d1", I_IRQ, DRAIN_V);
    cycle("irqdrop_d2", I_NONE, DRAIN_V);
    cycle("irqdrop_d3", I_NONE, DRAIN_V);
    cycle("irqdrop_redir", I_NONE, REDIR_V);
    cycle("irqdrop_after", I_NONE, RUN_V);

    cycle("mdr_d1", I_IRQ, DRAIN_V);
    cycle("mdr_hold1", I_IRQ | I_MB, HOLD_V);
    cycle("mdr_hold2", I_IRQ | I_MB, HOLD_V);
    check("mdr_state", {13'd0, state_dbg}, 16'd2);
    check("mdr_cnt_frozen", {13'd0, cnt_dbg}, 16'd2);
    cycle("mdr_hold3", I_IRQ | I_MB, HOLD_V);
    cycle("mdr_hold4", I_IRQ | I_MB, HOLD_V);
    cycle("mdr_d2", I_IRQ, DRAIN_V);
    cycle("mdr_d3", I_IRQ, DRAIN_V);
    cycle("mdr_redir_mb", I_IRQ | I_MB, REDIR_V);
    cycle("mdr_run_mb", I_MB, HOLD_V);
    cycle("mdr_after", I_NONE, RUN_V);

    cycle("brirq_c1", I_BR, BUB_V);
    cycle("brirq_c2", I_IRQ, BUB_V);
    cycle("brirq_d1", I_IRQ, DRAIN_V);
    cycle("brirq_d2", I_IRQ, DRAIN_V);
    cycle("brirq_d3", I_IRQ, DRAIN_V);
    cycle("brirq_redir", I_IRQ, REDIR_V);
    cycle("brirq_after", I_NONE, RUN_V);

    cycle("rd_lu", I_RD | I_LU, BUB_V);
    cycle("rd_alone", I_RD, KILL_V);
    cycle("rd_after", I_NONE, RUN_V);
    cycle("rd_mb", I_RD | I_MB, HOLD_V);
    cycle("rd_mb_after", I_NONE, RUN_V);

    cycle("brmb_c1", I_BR, BUB_V);
    cycle("brmb_hold", I_MB, HOLD_V);
    cycle("brmb_c2", I_NONE, BUB_V);
    cycle("brmb_done", I_NONE, RUN_V);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
